ifetch_buffer: RTL

Parametrised instruction-fetch stage for the TPU scalar unit, between the instruction memory and the decode stage. It issues read-enables to the instruction memory and tracks reads in flight across a configurable memory latency. Returned instructions go into a DEPTH-entry queue, and the queue drives decode through a valid/ready handshake. Adds credit-based flow control, back-pressure, termination drain and flush.

---
 rtl/ifetch_buffer_pkg.sv | 21 ++
 rtl/ifetch_fifo.sv | 46 ++++
 rtl/ifetch_buffer.sv | 117 +++++++++++
 3 files changed

// File: rtl/ifetch_buffer_pkg.sv
// Shared types for the TPU scalar-unit fetch path.
package pkg_tpu;

  localparam int unsigned INSTR_W = 32;

  typedef logic [INSTR_W-1:0] instruction_t;

  // Instruction-memory return: valid flag plus the fetched word.
  typedef struct packed {
    logic         v;
    instruction_t instr;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    FLUSH
  } fetch_state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous instruction queue. Clear wins over push/pop; head reads zero while empty.
module ifetch_fifo
  import pkg_tpu::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  instruction_t                 din,
  output instruction_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  instruction_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage is not reset; the head mux hides stale entries.
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign head  = (count_q != '0) ? mem[rd_ptr] : '0;
  assign count = count_q;

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction-fetch stage: credit-limited issue to instruction memory, in-flight
// tracking across RD_LAT cycles, and a DEPTH-entry queue feeding decode.
module ifetch_buffer
  import pkg_tpu::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        I_Req,
  input  logic                        I_Empty,
  input  logic                        I_Term,
  input  logic                        I_Flush,
  input  instr_t                      I_Instr,
  output logic                        O_Re_Instr,
  output logic                        O_Req,
  input  logic                        I_Ready,
  output instruction_t                O_Instr,
  output logic [$clog2(DEPTH+1)-1:0]  O_Count,
  output logic                        O_Idle
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = $clog2(DEPTH+RD_LAT+1);

  fetch_state_t      state_q, state_d;
  logic [RD_LAT-1:0] issued_q, issued_d;
  logic [RD_LAT-1:0] squash_q, squash_d;
  logic [SW-1:0]     inflight, inflight_nxt;
  logic [CW-1:0]     count_nxt;
  logic              idle_q;
  logic              push, pop;

  // Credits count queue entries plus reads in flight, before any same-cycle pop.
  assign O_Re_Instr = (state_q == FETCH) & ~I_Empty & ~I_Term & ~I_Flush &
                      ((SW'(O_Count) + inflight) < SW'(DEPTH));

  // Oldest tracker stage lines up with the memory return; a flush this cycle also squashes it.
  assign push = issued_q[RD_LAT-1] & ~(squash_q[RD_LAT-1] | I_Flush) & I_Instr.v;
  assign pop  = O_Req & I_Ready;

  assign O_Req     = (O_Count != '0);
  assign count_nxt = I_Flush ? '0 : O_Count + CW'(push) - CW'(pop);
  assign O_Idle    = idle_q;

  // Tracker shift: new issue enters stage 0, flush marks every live stage as squashed.
  always_comb begin
    issued_d    = '0;
    squash_d    = '0;
    issued_d[0] = O_Re_Instr;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      issued_d[i] = issued_q[i-1];
      squash_d[i] = issued_q[i-1] & (squash_q[i-1] | I_Flush);
    end
  end

  // Reads currently in flight.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) inflight = inflight + SW'(issued_q[i]);
  end

  // Reads in flight after this edge, for the registered idle flag.
  always_comb begin
    inflight_nxt = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) inflight_nxt = inflight_nxt + SW'(issued_d[i]);
  end

  // Next state; flush overrides everything, term only matters while fetching.
  always_comb begin
    state_d = state_q;
    if (I_Flush) begin
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        IDLE:    if (I_Req) state_d = FETCH;
        FETCH: begin
          if (I_Term)      state_d = DRAIN;
          else if (!I_Req) state_d = IDLE;
        end
        DRAIN:   if (inflight == '0 && O_Count == '0) state_d = IDLE;
        FLUSH:   if (inflight == '0) state_d = I_Req ? FETCH : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, tracker and idle flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      issued_q <= '0;
      squash_q <= '0;
      idle_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      squash_q <= squash_d;
      idle_q   <= (state_d == IDLE) && (count_nxt == '0) && (inflight_nxt == '0);
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (I_Flush),
    .din   (I_Instr.instr),
    .head  (O_Instr),
    .count (O_Count)
  );

endmodule
